// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed leaky integrate-and-fire neuron array with spike FIFO
module lif_neuron_array #(
  parameter int N_NEURONS   = 4,
  parameter int NEURON_ID_W = 2,
  parameter int SCORE_W     = 4,
  parameter int VMEM_W      = 16,
  parameter int LEAK_SHIFT  = 4,
  parameter int REFRACT_W   = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   score_valid,
  output logic                   score_ready,
  input  logic [NEURON_ID_W-1:0] score_nid,
  input  logic [SCORE_W-1:0]     score_in,
  input  logic                   scan_start,
  input  logic [VMEM_W-1:0]      threshold,
  input  logic [REFRACT_W-1:0]   refract_len,
  output logic                   busy,
  output logic                   scan_overrun,
  output logic                   spike_valid,
  output logic [NEURON_ID_W-1:0] spike_id,
  input  logic                   spike_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [NEURON_ID_W-1:0] LAST_IDX  = NEURON_ID_W'(N_NEURONS - 1);
  localparam logic [NEURON_ID_W-1:0] NID_ONE   = NEURON_ID_W'(1);
  localparam logic [NEURON_ID_W:0]   NID_LIMIT = (NEURON_ID_W + 1)'(N_NEURONS);
  localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);
  localparam logic [REFRACT_W-1:0]   REFR_ONE  = REFRACT_W'(1);
  localparam logic [VMEM_W-1:0]      VMEM_MAX  = '1;

  typedef enum logic {ACCUM, SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [NEURON_ID_W-1:0]  idx_q, idx_d;
  logic [VMEM_W-1:0]       vmem_q [N_NEURONS];
  logic [VMEM_W-1:0]       vmem_d [N_NEURONS];
  logic [REFRACT_W-1:0]    refr_q [N_NEURONS];
  logic [REFRACT_W-1:0]    refr_d [N_NEURONS];
  logic [NEURON_ID_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [NEURON_ID_W-1:0]  fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NEURON_ID_W-1:0]  last_id_q, last_id_d;
  logic                    overrun_q, overrun_d;

  // Datapath terms for the neuron currently under evaluation and the score target
  logic [VMEM_W-1:0]    cur_v, leak_v;
  logic [REFRACT_W-1:0] cur_r;
  logic                 fire_want, fifo_full, pop, nid_ok;
  logic [VMEM_W:0]      score_sum;

  assign cur_v     = vmem_q[idx_q];
  assign cur_r     = refr_q[idx_q];
  assign leak_v    = cur_v - (cur_v >> LEAK_SHIFT);
  assign fire_want = (cur_r == '0) && (leak_v >= threshold);
  assign fifo_full = (count_q == CNT_FULL);
  assign pop       = spike_valid && spike_ready;
  assign nid_ok    = ({1'b0, score_nid} < NID_LIMIT);
  assign score_sum = {1'b0, vmem_q[score_nid]} + (VMEM_W + 1)'(score_in);

  assign score_ready  = (state_q == ACCUM);
  assign busy         = (state_q == SWEEP);
  assign scan_overrun = overrun_q;
  assign spike_valid  = (count_q != '0);
  assign spike_id     = spike_valid ? fifo_q[rptr_q] : last_id_q;

  // Next-state: score integration, sweep evaluation with FIFO-full stall, spike FIFO bookkeeping
  always_comb begin
    logic push;
    state_d   = state_q;
    idx_d     = idx_q;
    vmem_d    = vmem_q;
    refr_d    = refr_q;
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    last_id_d = last_id_q;
    overrun_d = 1'b0;
    push      = 1'b0;

    case (state_q)
      ACCUM: begin
        if (score_valid && nid_ok && (refr_q[score_nid] == '0)) begin
          vmem_d[score_nid] = score_sum[VMEM_W] ? VMEM_MAX : score_sum[VMEM_W-1:0];
        end
        if (scan_start) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        overrun_d = scan_start;
        // A fire into a full FIFO waits unless a pop frees a slot this cycle
        if (!(fire_want && fifo_full && !pop)) begin
          if (cur_r != '0) begin
            refr_d[idx_q] = cur_r - REFR_ONE;
            vmem_d[idx_q] = leak_v;
          end else if (fire_want) begin
            push          = 1'b1;
            vmem_d[idx_q] = '0;
            refr_d[idx_q] = refract_len;
          end else begin
            vmem_d[idx_q] = leak_v;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ACCUM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + NID_ONE;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        idx_d   = '0;
      end
    endcase

    if (push) begin
      fifo_d[wptr_q] = idx_q;
      wptr_d         = wptr_q + PTR_ONE;
    end
    if (pop) begin
      last_id_d = fifo_q[rptr_q];
      rptr_d    = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears every neuron, the FIFO and any sweep in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      last_id_q <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        vmem_q[i] <= '0;
        refr_q[i] <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vmem_q    <= vmem_d;
      refr_q    <= refr_d;
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      last_id_q <= last_id_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed scoreboard bench for lif_neuron_array
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        score_valid;
  logic        score_ready;
  logic [1:0]  score_nid;
  logic [3:0]  score_in;
  logic        scan_start;
  logic [15:0] threshold;
  logic [2:0]  refract_len;
  logic        busy;
  logic        scan_overrun;
  logic        spike_valid;
  logic [1:0]  spike_id;
  logic        spike_ready;

  int tests = 0;
  int fails = 0;
  int sb[$];

  lif_neuron_array #(
    .N_NEURONS(4), .NEURON_ID_W(2), .SCORE_W(4), .VMEM_W(16),
    .LEAK_SHIFT(4), .REFRACT_W(3), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_nid(score_nid), .score_in(score_in),
    .scan_start(scan_start), .threshold(threshold), .refract_len(refract_len),
    .busy(busy), .scan_overrun(scan_overrun),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int nid, input int val);
    score_valid = 1'b1;
    score_nid   = 2'(nid);
    score_in    = 4'(val);
    tick();
    score_valid = 1'b0;
  endtask

  task automatic scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      n++;
      tick();
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_vmem(input string tag, input int i, input int exp);
    check(tag, dut.vmem_q[i], exp);
  endtask

  // Spike monitor: every delivered ID must be the oldest predicted one
  always @(negedge clk) begin
    int exp_id;
    if (!rst && spike_valid && spike_ready) begin
      exp_id = (sb.size() > 0) ? sb.pop_front() : 255;
      check("spike_id", spike_id, exp_id);
    end
  end

  initial begin
    int n;
    score_valid = 1'b0; score_nid = '0; score_in = '0; scan_start = 1'b0;
    threshold = 16'd100; refract_len = 3'd0; spike_ready = 1'b1;
    do_reset();

    check("rst_score_ready", score_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_overrun", scan_overrun, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_id", spike_id, 0);

    // 120 on nid 2, last score in the scan_start cycle; 113 >= 100 fires
    repeat (7) send(2, 15);
    check_vmem("t1_vmem2_pre", 2, 105);
    score_valid = 1'b1; score_nid = 2'd2; score_in = 4'd15; scan_start = 1'b1;
    sb.push_back(2);
    tick();
    score_valid = 1'b0; scan_start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_score_ready", score_ready, 0);
    wait_idle(n);
    check("t1_sweep_len", n, 4);
    check_vmem("t1_vmem2_post", 2, 0);
    wait_drain("t1_drain");

    // 105 leaks to 99 (no fire), then 93
    repeat (7) send(1, 15);
    scan();
    wait_idle(n);
    check_vmem("t2_vmem1_a", 1, 99);
    scan();
    wait_idle(n);
    check_vmem("t2_vmem1_b", 1, 93);
    check("t2_no_spike", spike_valid, 0);

    // Saturation on nid 0
    repeat (4368) send(0, 15);
    send(0, 10);
    check_vmem("t3_vmem0_65530", 0, 65530);
    send(0, 15);
    check_vmem("t3_vmem0_sat", 0, 65535);
    threshold = 16'hFFFF;
    scan();
    wait_idle(n);
    check_vmem("t3_vmem0_leak", 0, 61440);
    check_vmem("t3_vmem1_leak", 1, 88);
    check("t3_no_spike", spike_valid, 0);

    // Refractory period of two scans on nid 3
    do_reset();
    threshold = 16'd100; refract_len = 3'd2;
    repeat (8) send(3, 15);
    sb.push_back(3);
    scan();
    wait_idle(n);
    check_vmem("t4_fire", 3, 0);
    wait_drain("t4_drain_a");
    repeat (8) send(3, 15);
    check_vmem("t4_discard_a", 3, 0);
    scan();
    wait_idle(n);
    repeat (8) send(3, 15);
    check_vmem("t4_discard_b", 3, 0);
    scan();
    wait_idle(n);
    repeat (8) send(3, 15);
    check_vmem("t4_accept", 3, 120);
    sb.push_back(3);
    scan();
    wait_idle(n);
    check_vmem("t4_refire", 3, 0);
    wait_drain("t4_drain_b");

    // Backpressure: depth-2 FIFO stalls the sweep at idx 2
    do_reset();
    threshold = 16'd100; refract_len = 3'd0; spike_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (13) send(i, 15);
      send(i, 5);
      check_vmem("t5_vmem_load", i, 200);
    end
    for (int i = 0; i < 4; i++) sb.push_back(i);
    scan();
    repeat (6) tick();
    check("t5_busy_stall", busy, 1);
    check("t5_ready_stall", score_ready, 0);
    check("t5_head_valid", spike_valid, 1);
    check("t5_head_id", spike_id, 0);
    check_vmem("t5_vmem2_held", 2, 200);
    spike_ready = 1'b1;
    wait_idle(n);
    check("t5_busy_done", busy, 0);
    wait_drain("t5_drain");
    for (int i = 0; i < 4; i++) check_vmem("t5_vmem_clear", i, 0);

    // Threshold 0 fires every non-refractory neuron
    threshold = 16'd0;
    for (int i = 0; i < 4; i++) sb.push_back(i);
    scan();
    wait_idle(n);
    check("t6_sweep_len", n, 4);
    wait_drain("t6_drain");

    // scan_start during a sweep
    threshold = 16'd100;
    scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("t7_overrun_hi", scan_overrun, 1);
    tick();
    check("t7_overrun_lo", scan_overrun, 0);
    wait_idle(n);
    repeat (3) tick();
    check("t7_no_second_sweep", busy, 0);

    // Reset at idx 1 abandons the sweep and its pending spike
    spike_ready = 1'b0;
    repeat (8) send(0, 15);
    scan();
    tick();
    check("t8_spike_pending", spike_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_spike_valid", spike_valid, 0);
    check("t8_busy", busy, 0);
    check("t8_score_ready", score_ready, 1);
    for (int i = 0; i < 4; i++) check_vmem("t8_vmem", i, 0);
    spike_ready = 1'b1;
    repeat (3) tick();
    check("t8_no_late_spike", spike_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one datapath. It is the parametrised successor to the single-neuron LIF top. Per-neuron membrane voltage and refractory state live in register arrays. Scores are integrated during the accumulate phase; each scan_start triggers one evaluation sweep (leak, threshold, fire, reset) over all neurons. Spike IDs are buffered in an internal FIFO and delivered to the downstream spike router over a valid/ready interface.

Parameters:
N_NEURONS, 4, number of neurons; must be >= 2.
NEURON_ID_W, 2, neuron index width; must be >= clog2(N_NEURONS).
SCORE_W, 4, unsigned score width.
VMEM_W, 16, unsigned membrane voltage width.
LEAK_SHIFT, 4, leak amount = vmem >> LEAK_SHIFT.
REFRACT_W, 3, width of each refractory counter.
FIFO_DEPTH, 4, spike FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
score_valid  in  1  score present this cycle
score_ready  out  1  array accepting scores (1 in ACCUM, 0 in SWEEP)
score_nid  in  NEURON_ID_W  target neuron
score_in  in  SCORE_W  score value
scan_start  in  1  single-cycle pulse: start evaluation sweep
threshold  in  VMEM_W  firing threshold shared by all neurons
refract_len  in  REFRACT_W  refractory scans loaded on fire
busy  out  1  sweep in progress
scan_overrun  out  1  one-cycle pulse: scan_start dropped
spike_valid  out  1  spike FIFO non-empty
spike_id  out  NEURON_ID_W  neuron ID at FIFO head
spike_ready  in  1  consumer pops head when valid & ready

Behaviour:
- Reset, in the cycle rst=1: all vmem=0, all refractory counters=0, FIFO emptied, FSM=ACCUM, sweep index=0. Outputs after reset: score_ready=1, busy=0, scan_overrun=0, spike_valid=0, spike_id=0.
- FSM states are ACCUM and SWEEP.
- ACCUM:
  - A score is accepted when score_valid & score_ready.
  - An accepted score sets vmem[score_nid] = min(vmem + score_in, 2^VMEM_W-1), i.e. a saturating add visible the next cycle.
  - A score is discarded if its target's refractory counter is nonzero, or if score_nid >= N_NEURONS.
  - scan_start moves the FSM to SWEEP with idx=0. A score accepted in the same cycle as scan_start is integrated before the sweep begins.
- SWEEP: evaluates neuron idx in one cycle, then increments idx.
  - Leaked value: v' = vmem - (vmem >> LEAK_SHIFT).
  - If refractory != 0: refractory decrements by 1, vmem = v', no fire.
  - Else if v' >= threshold: push idx into the FIFO, vmem = 0, refractory = refract_len.
  - Else: vmem = v'.
  - Stall: if the FIFO is full in a cycle whose evaluation would fire, hold idx and all state unchanged for that neuron and retry next cycle. Pop and push in the same cycle is legal, so a pop frees the slot in that cycle.
  - After idx = N_NEURONS-1 completes: FSM returns to ACCUM and idx resets to 0.
  - Each neuron fires at most once per scan; a sweep lasts N_NEURONS cycles when unstalled.
  - busy=1 and score_ready=0 throughout SWEEP.
  - scan_start arriving in SWEEP is ignored and produces scan_overrun=1 for one cycle.
- FIFO: registered. spike_valid rises the cycle after the first push into an empty FIFO. IDs are delivered in push order. Simultaneous push and pop when full is allowed and the count stays unchanged. While spike_valid=0, spike_id holds its last value (0 after reset).
- Threshold 0: every non-refractory neuron fires on each sweep.
- Reset mid-sweep: the sweep is abandoned and the full reset state applies on the next cycle; no partial spikes are retained.

Test Plan:
- Defaults, threshold=100: 8 scores of 15 to nid 2 (vmem=120), then scan_start -> leak 120-7=113 -> spike_id=2 appears; vmem[2]=0; sweep takes 4 cycles with busy=1.
- 7 scores of 15 to nid 1 (vmem=105), scan -> v'=99, no spike, vmem[1]=99. Next scan with no new scores -> 99-6=93, no spike.
- Saturation: drive vmem[0] to 65530, add 15 -> 65535. threshold=65535 and scan -> 65535-4095=61440, no spike.
- Refractory: refract_len=2; nid 3 fires; scores to nid 3 over the next two scans are discarded and no fire occurs; on the third scan the neuron accepts scores and can fire again.
- Backpressure: FIFO_DEPTH=2, spike_ready=0, all four neurons at vmem=200, threshold=100 -> IDs 0,1 pushed, sweep stalls at idx 2 with busy=1 and score_ready=0. Raise spike_ready -> IDs emerge in order 0,1,2,3 and busy drops.
- scan_start during a sweep -> scan_overrun pulses for 1 cycle, with no second sweep. Assert rst at idx 1 -> next cycle spike_valid=0, busy=0, all vmem=0.
